axi_window_guard: RTL and testbench

- AXI4 guard placed directly upstream of the DDR address mapper, on the path from the core memory port.
- Forwards transactions that fall entirely inside a 2^WINDOW_BITS-byte window with zero added latency.
- Out-of-window transactions are never forwarded: the block terminates them locally with DECERR, in AXI ordering with forwarded traffic.
- Stops stray addresses from aliasing into the PS DRAM once the mapper truncates to 28 bits.

---
 rtl/axi_window_guard.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_axi_window_guard.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_window_guard.sv
// axi_window_guard: AXI4 range guard between the core memory port and the
// DDR address mapper. Bursts that lie entirely inside [0, 2^WINDOW_BITS)
// pass straight through with no added latency. Any other burst is never
// forwarded. The guard waits until all earlier forwarded traffic in that
// direction has drained, then answers the burst locally with DECERR, so
// responses keep AXI ordering.
//
// Ports:
//   clk, reset  - clock; asynchronous active-high reset
//   s_axi_*     - AXI4 slave from the core (64-bit data, 4-bit id)
//   m_axi_*     - AXI4 master of identical shape, feeding the mapper
//   err_count   - saturating count of DECERR-terminated bursts (R + B)
module axi_window_guard #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WINDOW_BITS     = 28,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  // slave AR
  input  logic [3:0]            s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // slave R
  output logic [3:0]            s_axi_rid,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_ruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  // slave AW
  input  logic [3:0]            s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awuser,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  // slave W
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wuser,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // slave B
  output logic [3:0]            s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_buser,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // master AR
  output logic [3:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // master R
  input  logic [3:0]            m_axi_rid,
  input  logic [63:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_ruser,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // master AW
  output logic [3:0]            m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awuser,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // master W
  output logic [63:0]           m_axi_wdata,
  output logic [7:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wuser,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // master B
  input  logic [3:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_buser,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [15:0]           err_count
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]       MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] WIN_END = ONE << WINDOW_BITS;

  // One bit of headroom keeps the end address from wrapping near the top
  // of the address space. WRAP bursts get the INCR footprint, which only
  // ever over-estimates.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len,
                                     input logic [2:0] size);
    logic [ADDR_WIDTH:0] nbytes;
    logic [ADDR_WIDTH:0] end_a;
    nbytes = ((ADDR_WIDTH+1)'(len) + ONE) << size;
    end_a  = {1'b0, addr} + nbytes;
    return ((addr >> WINDOW_BITS) == '0) && (end_a <= WIN_END);
  endfunction

  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_SINK, W_RESP} wr_state_t;

  rd_state_t       rd_state, rd_next;
  wr_state_t       wr_state, wr_next;
  logic [CW-1:0]   rd_out, wr_out, w_pend;
  logic [3:0]      rd_err_id, wr_err_id;
  logic [7:0]      rd_err_len, rd_beat;
  logic            rd_err_done, wr_err_done;

  wire ar_ok   = in_window(s_axi_araddr, s_axi_arlen, s_axi_arsize);
  wire aw_ok   = in_window(s_axi_awaddr, s_axi_awlen, s_axi_awsize);
  wire rd_room = rd_out < MAX_OUT;
  wire wr_room = wr_out < MAX_OUT;

  wire m_ar_hs     = m_axi_arvalid & m_axi_arready;
  wire m_rlast_hs  = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  wire m_aw_hs     = m_axi_awvalid & m_axi_awready;
  wire m_wlast_hs  = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  wire m_b_hs      = m_axi_bvalid & m_axi_bready;
  wire ar_err_take = (rd_state == R_IDLE) & s_axi_arvalid & ~ar_ok;
  wire aw_err_take = (wr_state == W_IDLE) & s_axi_awvalid & ~aw_ok;
  // W may only enter the mapper behind an AW that has already gone out
  // (or goes out this cycle).
  wire w_open      = (w_pend != '0) | m_aw_hs;

  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = s_axi_arqos;
  assign m_axi_aruser  = s_axi_aruser;
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = s_axi_awqos;
  assign m_axi_awuser  = s_axi_awuser;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wuser   = s_axi_wuser;

  // Read side. An out-of-range AR is accepted as soon as it is presented;
  // ready depends on the address check only, never on arvalid.
  always_comb begin
    rd_next       = rd_state;
    rd_err_done   = 1'b0;
    m_axi_arvalid = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = m_axi_rvalid;
    s_axi_rid     = m_axi_rid;
    s_axi_rdata   = m_axi_rdata;
    s_axi_rresp   = m_axi_rresp;
    s_axi_rlast   = m_axi_rlast;
    s_axi_ruser   = m_axi_ruser;
    m_axi_rready  = s_axi_rready;
    case (rd_state)
      R_IDLE: begin
        if (ar_ok) begin
          m_axi_arvalid = s_axi_arvalid & rd_room;
          s_axi_arready = m_axi_arready & rd_room;
        end else begin
          s_axi_arready = 1'b1;
          if (s_axi_arvalid) rd_next = R_DRAIN;
        end
      end
      R_DRAIN: if (rd_out == '0) rd_next = R_ERR;
      R_ERR: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = rd_err_id;
        s_axi_rdata  = '0;
        s_axi_rresp  = 2'b11;
        s_axi_rlast  = (rd_beat == rd_err_len);
        s_axi_ruser  = 1'b0;
        m_axi_rready = 1'b0;
        if (s_axi_rready && rd_beat == rd_err_len) begin
          rd_err_done = 1'b1;
          rd_next     = R_IDLE;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Write address side.
  always_comb begin
    m_axi_awvalid = 1'b0;
    s_axi_awready = 1'b0;
    if (wr_state == W_IDLE) begin
      if (aw_ok) begin
        m_axi_awvalid = s_axi_awvalid & wr_room;
        s_axi_awready = m_axi_awready & wr_room;
      end else begin
        s_axi_awready = 1'b1;
      end
    end
  end

  // Write data/response side and write state sequencing.
  always_comb begin
    wr_next      = wr_state;
    wr_err_done  = 1'b0;
    m_axi_wvalid = s_axi_wvalid & w_open;
    s_axi_wready = m_axi_wready & w_open;
    s_axi_bvalid = m_axi_bvalid;
    s_axi_bid    = m_axi_bid;
    s_axi_bresp  = m_axi_bresp;
    s_axi_buser  = m_axi_buser;
    m_axi_bready = s_axi_bready;
    case (wr_state)
      W_IDLE:  if (aw_err_take) wr_next = W_DRAIN;
      W_DRAIN: if (w_pend == '0 && wr_out == '0) wr_next = W_SINK;
      W_SINK: begin
        m_axi_wvalid = 1'b0;
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = wr_err_id;
        s_axi_bresp  = 2'b11;
        s_axi_buser  = 1'b0;
        m_axi_bready = 1'b0;
        if (s_axi_bready) begin
          wr_err_done = 1'b1;
          wr_next     = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  wire [16:0] err_sum = {1'b0, err_count} + 17'(rd_err_done) + 17'(wr_err_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state   <= R_IDLE;
      wr_state   <= W_IDLE;
      rd_out     <= '0;
      wr_out     <= '0;
      w_pend     <= '0;
      rd_err_id  <= '0;
      rd_err_len <= '0;
      rd_beat    <= '0;
      wr_err_id  <= '0;
      err_count  <= '0;
    end else begin
      rd_state  <= rd_next;
      wr_state  <= wr_next;
      rd_out    <= rd_out + CW'(m_ar_hs) - CW'(m_rlast_hs);
      wr_out    <= wr_out + CW'(m_aw_hs) - CW'(m_b_hs);
      w_pend    <= w_pend + CW'(m_aw_hs) - CW'(m_wlast_hs);
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (ar_err_take) begin
        rd_err_id  <= s_axi_arid;
        rd_err_len <= s_axi_arlen;
        rd_beat    <= '0;
      end else if (rd_state == R_ERR && s_axi_rready) begin
        rd_beat <= rd_beat + 8'd1;
      end
      if (aw_err_take) wr_err_id <= s_axi_awid;
    end
  end

endmodule

// File: tb/tb_axi_window_guard.sv
module tb_axi_window_guard;
  localparam int AW = 32;
  localparam int WB = 28;

  logic clk, reset;
  logic [3:0] s_axi_arid, s_axi_awid, s_axi_rid, s_axi_bid, m_axi_arid, m_axi_awid, m_axi_rid, m_axi_bid;
  logic [AW-1:0] s_axi_araddr, s_axi_awaddr, m_axi_araddr, m_axi_awaddr;
  logic [7:0] s_axi_arlen, s_axi_awlen, m_axi_arlen, m_axi_awlen, s_axi_wstrb, m_axi_wstrb;
  logic [2:0] s_axi_arsize, s_axi_awsize, m_axi_arsize, m_axi_awsize;
  logic [1:0] s_axi_arburst, s_axi_awburst, m_axi_arburst, m_axi_awburst;
  logic s_axi_arlock, s_axi_awlock, m_axi_arlock, m_axi_awlock;
  logic [3:0] s_axi_arcache, s_axi_awcache, m_axi_arcache, m_axi_awcache;
  logic [2:0] s_axi_arprot, s_axi_awprot, m_axi_arprot, m_axi_awprot;
  logic [3:0] s_axi_arqos, s_axi_awqos, m_axi_arqos, m_axi_awqos;
  logic s_axi_aruser, s_axi_awuser, m_axi_aruser, m_axi_awuser;
  logic s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic [63:0] s_axi_rdata, m_axi_rdata, s_axi_wdata, m_axi_wdata;
  logic [1:0] s_axi_rresp, m_axi_rresp, s_axi_bresp, m_axi_bresp;
  logic s_axi_rlast, m_axi_rlast, s_axi_ruser, m_axi_ruser;
  logic s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;
  logic s_axi_wlast, m_axi_wlast, s_axi_wuser, m_axi_wuser;
  logic s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
  logic s_axi_buser, m_axi_buser;
  logic s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic [15:0] err_count;

  int n_pass  = 0;
  int n_total = 0;
  int exp_err = 0;

  axi_window_guard #(.ADDR_WIDTH(AW), .WINDOW_BITS(WB), .MAX_OUTSTANDING(15)) dut (
    .clk, .reset,
    .s_axi_arid, .s_axi_araddr, .s_axi_arlen, .s_axi_arsize, .s_axi_arburst, .s_axi_arlock,
    .s_axi_arcache, .s_axi_arprot, .s_axi_arqos, .s_axi_aruser, .s_axi_arvalid, .s_axi_arready,
    .s_axi_rid, .s_axi_rdata, .s_axi_rresp, .s_axi_rlast, .s_axi_ruser, .s_axi_rvalid, .s_axi_rready,
    .s_axi_awid, .s_axi_awaddr, .s_axi_awlen, .s_axi_awsize, .s_axi_awburst, .s_axi_awlock,
    .s_axi_awcache, .s_axi_awprot, .s_axi_awqos, .s_axi_awuser, .s_axi_awvalid, .s_axi_awready,
    .s_axi_wdata, .s_axi_wstrb, .s_axi_wlast, .s_axi_wuser, .s_axi_wvalid, .s_axi_wready,
    .s_axi_bid, .s_axi_bresp, .s_axi_buser, .s_axi_bvalid, .s_axi_bready,
    .m_axi_arid, .m_axi_araddr, .m_axi_arlen, .m_axi_arsize, .m_axi_arburst, .m_axi_arlock,
    .m_axi_arcache, .m_axi_arprot, .m_axi_arqos, .m_axi_aruser, .m_axi_arvalid, .m_axi_arready,
    .m_axi_rid, .m_axi_rdata, .m_axi_rresp, .m_axi_rlast, .m_axi_ruser, .m_axi_rvalid, .m_axi_rready,
    .m_axi_awid, .m_axi_awaddr, .m_axi_awlen, .m_axi_awsize, .m_axi_awburst, .m_axi_awlock,
    .m_axi_awcache, .m_axi_awprot, .m_axi_awqos, .m_axi_awuser, .m_axi_awvalid, .m_axi_awready,
    .m_axi_wdata, .m_axi_wstrb, .m_axi_wlast, .m_axi_wuser, .m_axi_wvalid, .m_axi_wready,
    .m_axi_bid, .m_axi_bresp, .m_axi_buser, .m_axi_bvalid, .m_axi_bready,
    .err_count
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven 2 time units after the rising edge and sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: a burst is kept iff its last byte lies below 2^WB.
  function automatic bit model_in(input longint unsigned addr, input int len, input int size);
    longint unsigned last_excl;
    last_excl = addr + longint'(len + 1) * (longint'(1) << size);
    return last_excl <= (longint'(1) << WB);
  endfunction

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [3:0] id, input bit fwd);
    int t;
    logic [14:0] side;
    side = 15'($urandom);
    {s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_aruser} = side;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arid = id;
    s_axi_arvalid = 1'b1; m_axi_arready = 1'b1;
    t = 0; #1;
    while (!s_axi_arready && t < 20) begin tick(); #1; t++; end
    chk("ar_accept", 64'(s_axi_arready), 64'd1);
    chk("ar_forward", 64'(m_axi_arvalid), 64'(fwd));
    if (fwd) begin
      chk("ar_addr", 64'(m_axi_araddr), 64'(addr));
      chk("ar_len_size_id", 64'({m_axi_arlen, m_axi_arsize, m_axi_arid}), 64'({len, size, id}));
      chk("ar_sideband", 64'({m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_aruser}), 64'(side));
    end
    tick();
    s_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
  endtask

  task automatic recv_r(input logic [7:0] len, input logic [3:0] id, input bit fwd);
    int t;
    logic [63:0] d;
    s_axi_rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      if (fwd) begin
        d = {$urandom, $urandom};
        m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rid = id; m_axi_rresp = 2'b00;
        m_axi_rlast = (b == int'(len)); #1;
        chk("r_fwd_valid", 64'(s_axi_rvalid), 64'd1);
        chk("r_fwd_data", s_axi_rdata, d);
        chk("r_fwd_id_resp_last", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'({id, 2'b00, b == int'(len)}));
        chk("r_fwd_mready", 64'(m_axi_rready), 64'd1);
      end else begin
        m_axi_rvalid = 1'b0; t = 0; #1;
        while (!s_axi_rvalid && t < 20) begin tick(); #1; t++; end
        chk("r_err_valid", 64'(s_axi_rvalid), 64'd1);
        chk("r_err_data", s_axi_rdata, 64'd0);
        chk("r_err_id_resp_last", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'({id, 2'b11, b == int'(len)}));
        chk("r_err_mready", 64'(m_axi_rready), 64'd0);
      end
      tick();
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [3:0] id, input bit fwd);
    int t;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awid = id;
    s_axi_awburst = 2'($urandom); s_axi_awcache = 4'($urandom);
    s_axi_awvalid = 1'b1; m_axi_awready = 1'b1;
    t = 0; #1;
    while (!s_axi_awready && t < 20) begin tick(); #1; t++; end
    chk("aw_accept", 64'(s_axi_awready), 64'd1);
    chk("aw_forward", 64'(m_axi_awvalid), 64'(fwd));
    if (fwd) chk("aw_fields", 64'({m_axi_awaddr, m_axi_awid, m_axi_awburst, m_axi_awcache}),
                 64'({addr, id, s_axi_awburst, s_axi_awcache}));
    tick();
    s_axi_awvalid = 1'b0; m_axi_awready = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] len, input bit fwd);
    int t;
    logic [63:0] d;
    m_axi_wready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = 8'($urandom); s_axi_wlast = (b == int'(len));
      t = 0; #1;
      while (!s_axi_wready && t < 20) begin tick(); #1; t++; end
      chk("w_accept", 64'(s_axi_wready), 64'd1);
      chk("w_forward", 64'(m_axi_wvalid), 64'(fwd));
      if (fwd) chk("w_data_last", {m_axi_wdata[62:0], m_axi_wlast}, {d[62:0], b == int'(len)});
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; m_axi_wready = 1'b0;
  endtask

  task automatic recv_b(input logic [3:0] id, input bit fwd);
    int t;
    s_axi_bready = 1'b1;
    if (fwd) begin
      m_axi_bvalid = 1'b1; m_axi_bid = id; m_axi_bresp = 2'b00; #1;
      chk("b_fwd", 64'({s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready}), 64'({1'b1, id, 2'b00, 1'b1}));
    end else begin
      m_axi_bvalid = 1'b0; t = 0; #1;
      while (!s_axi_bvalid && t < 20) begin tick(); #1; t++; end
      chk("b_err", 64'({s_axi_bvalid, s_axi_bid, s_axi_bresp, m_axi_bready}), 64'({1'b1, id, 2'b11, 1'b0}));
    end
    tick();
    m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  ln;
    logic [2:0]  sz;
    logic [3:0]  id;
    bit          fwd;
    int          t;

    reset = 1'b1;
    {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock} = '0;
    {s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_aruser, s_axi_arvalid, s_axi_rready} = '0;
    {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock} = '0;
    {s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awuser, s_axi_awvalid} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser, s_axi_wvalid, s_axi_bready} = '0;
    {m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid} = '0;
    {m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid} = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // reset state
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_valids", 64'({s_axi_rvalid, s_axi_bvalid, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}), 64'd0);
    chk("rst_readies", 64'({s_axi_wready, m_axi_rready, m_axi_bready}), 64'd0);
    chk("rst_counters", 64'({dut.rd_out, dut.wr_out, dut.w_pend}), 64'd0);
    tick();

    // in-range read, forwarded with zero latency
    send_ar(32'h0000_1000, 8'd7, 3'd3, 4'd5, 1'b1);
    chk("rd_out_one", 64'(dut.rd_out), 64'd1);
    recv_r(8'd7, 4'd5, 1'b1);
    chk("rd_out_zero", 64'(dut.rd_out), 64'd0);
    chk("err_after_fwd", 64'(err_count), 64'd0);

    // out-of-range read, local DECERR
    send_ar(32'h1000_0000, 8'd3, 3'd3, 4'd2, 1'b0);
    recv_r(8'd3, 4'd2, 1'b0);
    exp_err++;
    chk("err_after_decerr", 64'(err_count), 64'(exp_err));

    // window boundary
    send_ar(32'h0FFF_FFC0, 8'd7, 3'd3, 4'd6, 1'b1);
    recv_r(8'd7, 4'd6, 1'b1);
    send_ar(32'h0FFF_FFC8, 8'd7, 3'd3, 4'd6, 1'b0);
    recv_r(8'd7, 4'd6, 1'b0);
    exp_err++;
    chk("err_after_boundary", 64'(err_count), 64'(exp_err));

    // DECERR waits behind an outstanding forwarded read
    send_ar(32'h0000_2000, 8'd0, 3'd3, 4'd1, 1'b1);
    send_ar(32'h1000_0000, 8'd1, 3'd3, 4'd1, 1'b0);
    s_axi_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("order_hold", 64'(s_axi_rvalid), 64'd0);
      tick();
    end
    recv_r(8'd0, 4'd1, 1'b1);
    recv_r(8'd1, 4'd1, 1'b0);
    exp_err++;
    chk("err_after_order", 64'(err_count), 64'(exp_err));

    // out-of-range AW behind a forwarded write with W still pending
    send_aw(32'h0000_3000, 8'd1, 3'd3, 4'd4, 1'b1);
    send_aw(32'h2000_0000, 8'd1, 3'd3, 4'd3, 1'b0);
    send_w(8'd1, 1'b1);
    recv_b(4'd4, 1'b1);
    send_w(8'd1, 1'b0);
    recv_b(4'd3, 1'b0);
    exp_err++;
    chk("err_after_write", 64'(err_count), 64'(exp_err));

    // outstanding limit: 15 in flight, 16th stalls until one completes
    s_axi_rready = 1'b1;
    for (int i = 0; i < 15; i++) send_ar(32'(i) << 8, 8'd0, 3'd3, 4'(i), 1'b1);
    s_axi_araddr = 32'h0000_8000; s_axi_arlen = 8'd0; s_axi_arsize = 3'd3; s_axi_arid = 4'd9;
    s_axi_arvalid = 1'b1; m_axi_arready = 1'b1; s_axi_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; chk("stall_ready", 64'({s_axi_arready, m_axi_arvalid}), 64'd0);
      tick();
    end
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 4'd0; #1;
    chk("stall_at_rlast", 64'({s_axi_arready, m_axi_rready}), 64'b01);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; #1;
    chk("stall_release", 64'({s_axi_arready, m_axi_arvalid}), 64'b11);
    tick();
    chk("rd_out_full", 64'(dut.rd_out), 64'd15);
    #1; chk("stall_again", 64'(s_axi_arready), 64'd0);
    reset = 1'b1; s_axi_arvalid = 1'b0; m_axi_arready = 1'b0; s_axi_rready = 1'b0;
    tick();
    chk("rst_mid_counters", 64'({dut.rd_out, dut.wr_out, dut.w_pend}), 64'd0);
    chk("rst_mid_err", 64'(err_count), 64'd0);
    chk("rst_mid_valids", 64'({s_axi_rvalid, s_axi_bvalid, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}), 64'd0);
    reset = 1'b0; exp_err = 0;
    tick();

    // reset in the middle of a local error burst drops it at once
    send_ar(32'h4000_0000, 8'd3, 3'd0, 4'd7, 1'b0);
    t = 0; #1;
    while (!s_axi_rvalid && t < 20) begin tick(); #1; t++; end
    chk("err_burst_started", 64'(s_axi_rvalid), 64'd1);
    reset = 1'b1; #1;
    chk("err_burst_abandoned", 64'(s_axi_rvalid), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, 32'h0FFF_0000));
        1:       a = 32'h0FFF_FF00 + 32'($urandom_range(0, 32'h1FF));
        default: a = $urandom;
      endcase
      ln  = 8'($urandom_range(0, 7));
      sz  = 3'($urandom_range(0, 3));
      id  = 4'($urandom);
      fwd = model_in(longint'(a), int'(ln), int'(sz));
      if ($urandom_range(0, 1) == 0) begin
        send_ar(a, ln, sz, id, fwd);
        recv_r(ln, id, fwd);
      end else begin
        send_aw(a, ln, sz, id, fwd);
        send_w(ln, fwd);
        recv_b(id, fwd);
      end
      if (!fwd) exp_err++;
    end
    chk("err_count_final", 64'(err_count), 64'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
